// File: rtl/vc_wrr_scheduler_if.sv
// vc_wrr_scheduler_if: VC-FIFO read side, D-FIFO write side and scheduler status
interface vc_wrr_scheduler_if #(
    parameter int DW = 6,
    parameter int WW = 4
);
    logic          init;
    logic [WW-1:0] weight_vc0;
    logic [WW-1:0] weight_vc1;
    logic          vc0_empty;
    logic          vc1_empty;
    logic          vc0_valid;
    logic          vc1_valid;
    logic [DW-1:0] vc0_data;
    logic [DW-1:0] vc1_data;
    logic          pause_d0;
    logic          pause_d1;
    logic          pop_vc0;
    logic          pop_vc1;
    logic          push_d0;
    logic          push_d1;
    logic [DW-1:0] data_out_d0;
    logic [DW-1:0] data_out_d1;
    logic [1:0]    grant;
    logic          sched_err;

    modport master (
        output init, weight_vc0, weight_vc1, vc0_empty, vc1_empty, vc0_valid, vc1_valid,
               vc0_data, vc1_data, pause_d0, pause_d1,
        input  pop_vc0, pop_vc1, push_d0, push_d1, data_out_d0, data_out_d1, grant, sched_err
    );

    modport slave (
        input  init, weight_vc0, weight_vc1, vc0_empty, vc1_empty, vc0_valid, vc1_valid,
               vc0_data, vc1_data, pause_d0, pause_d1,
        output pop_vc0, pop_vc1, push_d0, push_d1, data_out_d0, data_out_d1, grant, sched_err
    );
endinterface

// File: rtl/vc_wrr_scheduler.sv
// vc_wrr_scheduler: work-conserving weighted round-robin drain of VC0/VC1 into D0/D1
module vc_wrr_scheduler #(
    parameter int DW = 6,
    parameter int WW = 4
) (
    input logic              clk,
    input logic              reset,
    vc_wrr_scheduler_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'b00, VC0 = 2'b01, VC1 = 2'b10} state_t;

    state_t        state, state_n;
    logic [WW-1:0] cred, cred_n, w0, w1;
    logic          pop0, pop1, pop0_q, pop1_q;
    logic          ok, sel;
    logic [DW-1:0] word;

    assign ok          = !bus.pause_d0 && !bus.pause_d1;
    assign bus.pop_vc0 = pop0 && !reset;
    assign bus.pop_vc1 = pop1 && !reset;
    assign bus.grant   = state;
    assign sel         = bus.vc0_valid || bus.vc1_valid;
    assign word        = bus.vc0_valid ? bus.vc0_data : bus.vc1_data;

    // next owner, credit reload/decrement and pop generation
    always_comb begin
        state_n = state;
        cred_n  = cred;
        pop0    = 1'b0;
        pop1    = 1'b0;
        case (state)
            IDLE: begin
                if (!bus.vc0_empty) begin
                    state_n = VC0;
                    cred_n  = w0;
                end else if (!bus.vc1_empty) begin
                    state_n = VC1;
                    cred_n  = w1;
                end
            end
            VC0: begin
                if (!ok) begin
                    state_n = state;
                end else if (bus.vc0_empty) begin
                    state_n = bus.vc1_empty ? IDLE : VC1;
                    cred_n  = bus.vc1_empty ? cred : w1;
                end else begin
                    pop0 = 1'b1;
                    if (cred == WW'(1)) begin
                        state_n = bus.vc1_empty ? VC0 : VC1;
                        cred_n  = bus.vc1_empty ? w0 : w1;
                    end else begin
                        cred_n = cred - WW'(1);
                    end
                end
            end
            VC1: begin
                if (!ok) begin
                    state_n = state;
                end else if (bus.vc1_empty) begin
                    state_n = bus.vc0_empty ? IDLE : VC0;
                    cred_n  = bus.vc0_empty ? cred : w0;
                end else begin
                    pop1 = 1'b1;
                    if (cred == WW'(1)) begin
                        state_n = bus.vc0_empty ? VC1 : VC0;
                        cred_n  = bus.vc0_empty ? w1 : w0;
                    end else begin
                        cred_n = cred - WW'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // owner state, credit and weights; a zero weight is stored as 1 so every VC keeps a turn
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cred  <= '0;
            w0    <= WW'(1);
            w1    <= WW'(1);
        end else begin
            state <= state_n;
            cred  <= cred_n;
            if (bus.init) begin
                w0 <= (bus.weight_vc0 == '0) ? WW'(1) : bus.weight_vc0;
                w1 <= (bus.weight_vc1 == '0) ? WW'(1) : bus.weight_vc1;
            end
        end
    end

    // route returned word by bit 4 and flag valids that no pop asked for
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.push_d0     <= 1'b0;
            bus.push_d1     <= 1'b0;
            bus.data_out_d0 <= '0;
            bus.data_out_d1 <= '0;
            bus.sched_err   <= 1'b0;
            pop0_q          <= 1'b0;
            pop1_q          <= 1'b0;
        end else begin
            bus.push_d0     <= sel && !word[4];
            bus.push_d1     <= sel && word[4];
            bus.data_out_d0 <= (sel && !word[4]) ? word : '0;
            bus.data_out_d1 <= (sel && word[4]) ? word : '0;
            pop0_q          <= bus.pop_vc0;
            pop1_q          <= bus.pop_vc1;
            bus.sched_err   <= bus.sched_err || (bus.vc0_valid && bus.vc1_valid) ||
                               (bus.vc0_valid && !pop0_q) || (bus.vc1_valid && !pop1_q);
        end
    end
endmodule

// File: tb/tb_vc_wrr_scheduler.sv
// tb_vc_wrr_scheduler: VC FIFO models, directed pop-order vectors and a pop/push scoreboard
module tb_vc_wrr_scheduler;
    localparam int DW = 6;
    localparam int WW = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    vc_wrr_scheduler_if #(.DW(DW), .WW(WW)) bus ();
    vc_wrr_scheduler #(.DW(DW), .WW(WW)) dut (.clk(clk), .reset(reset), .bus(bus));

    logic [DW-1:0] mem0 [256];
    logic [DW-1:0] mem1 [256];
    int wr0 = 0, wr1 = 0, rd0 = 0, rd1 = 0;
    logic v0 = 1'b0, v1 = 1'b0, f0 = 1'b0, f1 = 1'b0;
    logic [DW-1:0] d0 = '0, d1 = '0;

    assign bus.vc0_empty = (rd0 == wr0);
    assign bus.vc1_empty = (rd1 == wr1);
    assign bus.vc0_valid = v0 | f0;
    assign bus.vc1_valid = v1 | f1;
    assign bus.vc0_data  = d0;
    assign bus.vc1_data  = d1;

    // VC FIFO read model: data valid one cycle after pop
    always @(posedge clk) begin
        v0 <= bus.pop_vc0;
        v1 <= bus.pop_vc1;
        if (bus.pop_vc0) begin
            d0  <= mem0[rd0[7:0]];
            rd0 <= rd0 + 1;
        end
        if (bus.pop_vc1) begin
            d1  <= mem1[rd1[7:0]];
            rd1 <= rd1 + 1;
        end
    end

    int checks = 0, errors = 0, cyc = 0;
    bit sb_off = 1'b0;
    int exp_pop [$];
    logic [DW:0] exp_push [$];
    int due [$];
    logic [DW-1:0] src0 [$];
    logic [DW-1:0] src1 [$];

    always @(posedge clk) cyc <= cyc + 1;

    int id, dc;
    logic [DW:0] e;
    logic ok_push;

    // monitor: compare every pop and push against the expected queues
    always @(negedge clk) begin
        if (!sb_off && !reset) begin
            if (bus.pop_vc0 || bus.pop_vc1) begin
                checks++;
                if (bus.pop_vc0 && bus.pop_vc1) begin
                    errors++;
                    $display("FAIL pop both pop_vc0 and pop_vc1 high, required one-hot");
                end else if (exp_pop.size() == 0) begin
                    errors++;
                    $display("FAIL pop unexpected pop vc%0d, required none", bus.pop_vc1);
                end else begin
                    id = exp_pop.pop_front();
                    if (int'(bus.pop_vc1) != id || bus.grant != (id == 1 ? 2'b10 : 2'b01)) begin
                        errors++;
                        $display("FAIL pop got vc%0d grant %b, required vc%0d", bus.pop_vc1, bus.grant, id);
                    end
                    due.push_back(cyc + 2);
                end
                if (bus.pause_d0 || bus.pause_d1) begin
                    errors++;
                    $display("FAIL pause_pop pop issued while paused, required none");
                end
            end
            if (bus.push_d0 || bus.push_d1) begin
                checks++;
                if (exp_push.size() == 0 || due.size() == 0) begin
                    errors++;
                    $display("FAIL push unexpected push d0=%b d1=%b, required none", bus.push_d0, bus.push_d1);
                end else begin
                    e  = exp_push.pop_front();
                    dc = due.pop_front();
                    ok_push = (bus.push_d1 == e[DW]) && (bus.push_d0 == !e[DW]) && (cyc == dc) &&
                              (e[DW] ? (bus.data_out_d1 == e[DW-1:0] && bus.data_out_d0 == '0)
                                     : (bus.data_out_d0 == e[DW-1:0] && bus.data_out_d1 == '0));
                    if (!ok_push) begin
                        errors++;
                        $display("FAIL push got d0=%b/%h d1=%b/%h cyc %0d, required d%0d=%h cyc %0d",
                                 bus.push_d0, bus.data_out_d0, bus.push_d1, bus.data_out_d1, cyc,
                                 e[DW], e[DW-1:0], dc);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h required %0h", nm, got, exp);
        end
    endtask

    task automatic load(input int vc, input logic [DW-1:0] w);
        if (vc == 0) begin
            mem0[wr0[7:0]] = w;
            wr0++;
            src0.push_back(w);
        end else begin
            mem1[wr1[7:0]] = w;
            wr1++;
            src1.push_back(w);
        end
    endtask

    task automatic expect_seq(input string s);
        logic [DW-1:0] w;
        for (int i = 0; i < s.len(); i++) begin
            if (s[i] == 8'h31) begin
                exp_pop.push_back(1);
                w = src1.pop_front();
            end else begin
                exp_pop.push_back(0);
                w = src0.pop_front();
            end
            exp_push.push_back({w[4], w});
        end
    endtask

    task automatic do_init(input logic [WW-1:0] a, input logic [WW-1:0] b);
        bus.weight_vc0 = a;
        bus.weight_vc1 = b;
        bus.init = 1'b1;
        tick(1);
        bus.init = 1'b0;
    endtask

    task automatic wait_drain(input string nm, input int lim);
        int n = 0;
        while ((exp_pop.size() != 0 || exp_push.size() != 0) && n < lim) begin
            @(posedge clk);
            n++;
        end
        #1;
        checks++;
        if (exp_pop.size() != 0 || exp_push.size() != 0) begin
            errors++;
            $display("FAIL %s timeout: %0d pops and %0d pushes outstanding, required 0",
                     nm, exp_pop.size(), exp_push.size());
        end
    endtask

    initial begin
        bus.init = 1'b0;
        bus.weight_vc0 = '0;
        bus.weight_vc1 = '0;
        bus.pause_d0 = 1'b0;
        bus.pause_d1 = 1'b0;
        tick(2);
        // words waiting in VC0 during reset: no pop until reset drops, then routed by bit 4
        load(0, 6'h05);
        load(0, 6'h15);
        expect_seq("00");
        tick(2);
        @(negedge clk);
        chk("rst_pop_vc0", bus.pop_vc0, 0);
        chk("rst_grant", bus.grant, 2'b00);
        chk("rst_push", {bus.push_d0, bus.push_d1}, 0);
        chk("rst_data", {bus.data_out_d0, bus.data_out_d1}, 0);
        chk("rst_err", bus.sched_err, 0);
        tick(1);
        reset = 1'b0;
        wait_drain("route", 50);

        // only VC1 non-empty, weights 2/2
        do_init(4'd2, 4'd2);
        load(1, 6'h2A);
        load(1, 6'h1B);
        load(1, 6'h33);
        expect_seq("111");
        @(negedge clk);
        chk("idle_grant", bus.grant, 2'b00);
        @(negedge clk);
        chk("vc1_pop_next", bus.pop_vc1, 1);
        chk("vc1_grant", bus.grant, 2'b10);
        wait_drain("vc1_only", 50);
        chk("idle_after", bus.grant, 2'b00);

        // weights 3/1, eight words each
        do_init(4'd3, 4'd1);
        for (int i = 0; i < 8; i++) begin
            load(0, 6'(i * 9));
            load(1, 6'(i * 5 + 32));
        end
        expect_seq("0001000100111111");
        wait_drain("wrr_3_1", 100);

        // same burst with pauses in the middle
        for (int i = 0; i < 8; i++) begin
            load(0, 6'(i * 11 + 3));
            load(1, 6'(i * 13 + 7));
        end
        expect_seq("0001000100111111");
        tick(6);
        bus.pause_d1 = 1'b1;
        tick(5);
        bus.pause_d1 = 1'b0;
        tick(2);
        bus.pause_d0 = 1'b1;
        tick(2);
        bus.pause_d0 = 1'b0;
        wait_drain("pause", 100);

        // zero weight stored as 1
        do_init(4'd0, 4'd2);
        for (int i = 0; i < 4; i++) begin
            load(0, 6'(i * 17 + 1));
            load(1, 6'(i * 19 + 2));
        end
        expect_seq("01101100");
        wait_drain("w0_zero", 60);

        // both valids together -> sticky error
        sb_off = 1'b1;
        f0 = 1'b1;
        f1 = 1'b1;
        tick(1);
        f0 = 1'b0;
        f1 = 1'b0;
        @(negedge clk);
        chk("err_both", bus.sched_err, 1);
        tick(3);
        chk("err_sticky", bus.sched_err, 1);

        // reset mid-burst
        for (int i = 0; i < 6; i++) load(0, 6'(i + 16));
        tick(3);
        reset = 1'b1;
        tick(1);
        @(negedge clk);
        chk("midrst_push", {bus.push_d0, bus.push_d1}, 0);
        chk("midrst_data", {bus.data_out_d0, bus.data_out_d1}, 0);
        chk("midrst_grant", bus.grant, 2'b00);
        chk("midrst_pop", {bus.pop_vc0, bus.pop_vc1}, 0);
        chk("midrst_err", bus.sched_err, 0);
        wr0 = rd0;
        wr1 = rd1;
        src0.delete();
        src1.delete();
        tick(1);
        reset = 1'b0;
        @(negedge clk);
        chk("postrst_push", {bus.push_d0, bus.push_d1}, 0);
        tick(1);
        @(negedge clk);
        chk("postrst_push2", {bus.push_d0, bus.push_d1}, 0);
        chk("postrst_grant", bus.grant, 2'b00);
        exp_pop.delete();
        exp_push.delete();
        due.delete();

        // valid with no pop behind it
        tick(1);
        f0 = 1'b1;
        tick(1);
        f0 = 1'b0;
        @(negedge clk);
        chk("err_nopop", bus.sched_err, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vc_wrr_scheduler.md
Name: vc_wrr_scheduler

Overview:
- Schedules draining of the two virtual-channel FIFOs (VC0, VC1) into the destination FIFOs (D0, D1) of the transaction layer.
- Replaces fixed VC0-over-VC1 priority with a work-conserving weighted round-robin.
- Generates VC pops, muxes the returned VC data, and demuxes it to D0/D1 by data bit 4.
- Stalls all pops while either destination FIFO signals pause (almost-full).

Parameters:
DW, 6, data width of VC/D FIFO words
WW, 4, width of per-VC weight and credit counters

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
init  input  1  one-cycle pulse: latch weight_vc0/weight_vc1
weight_vc0  input  WW  VC0 consecutive-pop quota
weight_vc1  input  WW  VC1 consecutive-pop quota
vc0_empty  input  1  VC0 FIFO empty flag
vc1_empty  input  1  VC1 FIFO empty flag
vc0_valid  input  1  VC0 FIFO read-data valid (1 cycle after pop)
vc1_valid  input  1  VC1 FIFO read-data valid
vc0_data  input  DW  VC0 FIFO read data
vc1_data  input  DW  VC1 FIFO read data
pause_d0  input  1  D0 FIFO almost-full
pause_d1  input  1  D1 FIFO almost-full
pop_vc0  output  1  pop VC0 (combinational)
pop_vc1  output  1  pop VC1 (combinational)
push_d0  output  1  push D0 (registered)
push_d1  output  1  push D1 (registered)
data_out_d0  output  DW  D0 write data (registered)
data_out_d1  output  DW  D1 write data (registered)
grant  output  2  one-hot current owner {VC1,VC0}; 00 = idle
sched_err  output  1  sticky protocol error

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; credits=0; weights=1.
  - push_d0/push_d1/data_out_d0/data_out_d1/sched_err=0; grant=00.
  - pop_vc0/pop_vc1 forced 0 while reset=1.
  - Reset mid-operation discards pipeline contents; no push on the cycle after reset.
- Weights:
  - Latched on the init cycle; a latched value of 0 is stored as 1.
  - New weights take effect at the next credit reload; the current credit is not altered.
- ok = !pause_d0 && !pause_d1.
- States and transitions:
  - IDLE (grant=00, no pops):
    - !vc0_empty -> VC0, cred=w0.
    - else !vc1_empty -> VC1, cred=w1.
  - VC0 (grant=01):
    - pop_vc0 = ok && !vc0_empty; each pop decrements cred.
    - On a pop with cred==1: if !vc1_empty -> VC1, cred=w1; else stay VC0, cred=w0.
    - If vc0_empty: if !vc1_empty -> VC1, cred=w1; else -> IDLE.
    - While paused, state and cred hold.
  - VC1: symmetric to VC0, with the VC roles swapped.
  - At most one pop per cycle; pop_vc0 and pop_vc1 are never both 1.
- Datapath latency and routing:
  - pop at cycle t -> FIFO valid at t+1 -> push registered at t+2.
  - At t+1 the valid VC is selected (vc0_valid over vc1_valid); data bit 4 routes: 0 -> D0, 1 -> D1.
  - push_dX <= selected valid && route; data_out_dX <= word if pushed, else 0.
- Pause margin: pause may assert after pops already issued; up to 2 words remain in flight. D FIFO almost-full thresholds leave >=2 free slots. The scheduler does not re-check pause on in-flight words.
- sched_err (sticky until reset), set on either:
  - vc0_valid && vc1_valid in the same cycle;
  - vcX_valid without pop_vcX in the previous cycle.
- Simultaneous init with a pop: the pop proceeds; weights update that cycle.

Test Plan:
- Weights 3/1, both VCs holding 8 words, no pause -> pop sequence VC0,VC0,VC0,VC1 repeating; grant 01,01,01,10; pushes 2 cycles after each pop.
- Only VC1 non-empty, weights 2/2 -> IDLE to VC1 in 1 cycle; back-to-back pop_vc1; IDLE and grant=00 once vc1_empty.
- Words 6'b000101 then 6'b010101 from VC0 -> push_d0=1 with data_out_d0=6'h05, then push_d1=1 with data_out_d1=6'h15; other side 0.
- pause_d1=1 for 5 cycles mid-burst -> pops 0 during pause, state/credit held; in-flight words still pushed; pattern resumes where it stopped.
- init with weight_vc0=0, weight_vc1=2 -> VC0 gets 1 pop per round, VC1 gets 2.
- Force vc0_valid and vc1_valid high together -> sched_err=1 next cycle and stays 1; reset mid-burst -> all outputs 0, state IDLE.
